// File: rtl/i_fetch.sv
`default_nettype none
// ============================================================================
// Module   : i_fetch
// Purpose  : Instruction-fetch stage with its own instruction memory. The
//            memory is loaded in LOAD, fetched in RUN, and the stage drains
//            the pipe in HALTED once the halt word has been fetched.
// Revision : 1.0 - initial release
// ============================================================================
module i_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF,
  localparam int                   AW         = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halt,
  output logic [1:0]            o_state
);

  localparam logic [1:0] ST_LOAD   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] cpc_q, cpc_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_advance;
  logic                  w_unused;

  // Word-aligned fetch; upper PC bits fall off so the address wraps.
  assign w_word     = mem_q[pc_q[AW+1:2]];
  assign w_pc_plus4 = pc_q + PC_STEP;
  assign w_target   = {i_pcbranch[DATA_WIDTH-1:2], 2'b00};
  assign w_advance  = i_enable && !i_stall;
  // Byte-offset bits of the branch target are forced to zero and never read.
  assign w_unused   = ^i_pcbranch[1:0];

  // Instruction memory: written only while loading, never reset.
  always_ff @(posedge i_clock) begin
    if (state_q == ST_LOAD && i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // State register and datapath registers with asynchronous clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
      instr_q <= '0;
      cpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cpc_q   <= cpc_d;
    end
  end

  // Next-state logic; the unused encoding falls back to LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:   if (i_enable && i_start) state_d = ST_RUN;
      ST_RUN:    if (w_advance && !i_branch && w_word == HALT_WORD) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_LOAD;
    endcase
  end

  // Output and datapath next values; stall outranks branch, branch outranks halt.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cpc_d   = cpc_q;
    o_halt  = (state_q == ST_HALTED);
    if (w_advance) begin
      case (state_q)
        ST_RUN: begin
          cpc_d = w_pc_plus4;
          if (i_branch) begin
            pc_d    = w_target;
            instr_d = '0;
          end else if (w_word == HALT_WORD) begin
            instr_d = HALT_WORD;
          end else begin
            pc_d    = w_pc_plus4;
            instr_d = w_word;
          end
        end
        ST_HALTED: instr_d = '0;
        default: ;
      endcase
    end
  end

  assign o_instruccion = instr_q;
  assign o_currentpc   = cpc_q;
  assign o_pc          = pc_q;
  assign o_state       = state_q;

endmodule
`default_nettype wire
